// File: rtl/dot_mmio_pkg.sv
// dot_mmio_pkg: shared constants and helpers for the dot-location readback window.
// Address map, coordinate width, status-word bit positions and the read-select type.
package dot_mmio_pkg;

  // Word addresses inside the data-memory map
  localparam int unsigned DOT_NUM_DOTS    = 450;
  localparam int unsigned DOT_X_BASE      = 100;
  localparam int unsigned DOT_Y_BASE      = 550;
  localparam int unsigned DOT_STATUS_ADDR = 1000;
  localparam int unsigned DOT_RNG_ADDR    = 99;

  // Stored bits per coordinate
  localparam int unsigned DOT_COORD_W = 10;

  // Status word layout
  localparam int unsigned DOT_STAT_PENDING_BIT = 0;
  localparam int unsigned DOT_STAT_OVERRUN_BIT = 1;
  localparam int unsigned DOT_STAT_COUNT_LSB   = 16;
  localparam int unsigned DOT_COUNT_W          = 16;

  // Which source a load returns on the next cycle
  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_X      = 2'd1,
    RD_Y      = 2'd2,
    RD_STATUS = 2'd3
  } dot_rd_sel_e;

  // Assemble the frame-status word from its fields
  function automatic logic [31:0] dot_status_word(
    input logic                   pending,
    input logic                   overrun,
    input logic [DOT_COUNT_W-1:0] count
  );
    logic [31:0] w;
    w = '0;
    w[DOT_STAT_PENDING_BIT]                 = pending;
    w[DOT_STAT_OVERRUN_BIT]                 = overrun;
    w[DOT_STAT_COUNT_LSB +: DOT_COUNT_W]    = count;
    return w;
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// vsync_edge_sync: brings the asynchronous active-low VGA vSync into the CPU
// clock domain with two flops and emits a one-cycle pulse on each falling edge.
module vsync_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic vsync_in,
  output logic frame_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Two-flop synchronizer plus one history flop; all idle high (vSync inactive)
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= vsync_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Falling edge of the synchronized vSync marks the start of a frame
  assign frame_edge = r_prev & ~r_sync2;

endmodule

// File: rtl/dot_mmio_readback.sv
// dot_mmio_readback: load-side responder for the dot X/Y tables and the
// frame-status register. Snoops processor stores into shadow X/Y tables and
// answers loads one cycle later, like the data RAM it sits beside.
// Optional feature macro: DOT_READBACK_FRAME_COUNT_EN builds the 16-bit frame
// counter in status bits[31:16]; without it those bits read 0.
module dot_mmio_readback
  import dot_mmio_pkg::*;
#(
  parameter int unsigned NUM_DOTS    = DOT_NUM_DOTS,
  parameter int unsigned X_BASE      = DOT_X_BASE,
  parameter int unsigned Y_BASE      = DOT_Y_BASE,
  parameter int unsigned STATUS_ADDR = DOT_STATUS_ADDR,
  parameter int unsigned COORD_W     = DOT_COORD_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wren,
  input  logic        rden,
  input  logic        vsync_in,
  output logic [31:0] rdata,
  output logic        hit
);

  localparam int unsigned IDX_W = $clog2(NUM_DOTS);

  // Address decode
  logic [31:0]       w_x_off;
  logic [31:0]       w_y_off;
  logic              w_x_in;
  logic              w_y_in;
  logic              w_st_in;
  logic [IDX_W-1:0]  w_x_idx;
  logic [IDX_W-1:0]  w_y_idx;
  dot_rd_sel_e       w_rd_sel;
  logic              w_status_rd;
  logic              w_frame_edge;
  logic [31:0]       w_status_word;
  logic [DOT_COUNT_W-1:0] w_frame_count;
  logic              w_unused_wdata;

  // Shadow coordinate tables (no reset: contents survive reset)
  logic [COORD_W-1:0] r_x_mem [NUM_DOTS];
  logic [COORD_W-1:0] r_y_mem [NUM_DOTS];

  logic [31:0] r_rdata;
  logic        r_hit;
  logic        r_frame_pending;
  logic        r_overrun;

  // An address below the base wraps to a huge offset, so one unsigned compare
  // covers both window bounds.
  assign w_x_off  = addr - X_BASE;
  assign w_y_off  = addr - Y_BASE;
  assign w_x_in   = (w_x_off < NUM_DOTS);
  assign w_y_in   = (w_y_off < NUM_DOTS);
  assign w_st_in  = (addr == STATUS_ADDR);
  assign w_x_idx  = w_x_off[IDX_W-1:0];
  assign w_y_idx  = w_y_off[IDX_W-1:0];

  // Only the low coordinate bits are stored
  assign w_unused_wdata = ^wdata[31:COORD_W];

  // Classify the current load by target window
  always_comb begin
    w_rd_sel = RD_NONE;
    if (rden) begin
      if (w_x_in) begin
        w_rd_sel = RD_X;
      end else if (w_y_in) begin
        w_rd_sel = RD_Y;
      end else if (w_st_in) begin
        w_rd_sel = RD_STATUS;
      end
    end
  end

  assign w_status_rd = (w_rd_sel == RD_STATUS);

  vsync_edge_sync u_vsync_edge_sync (
    .clock      (clock),
    .reset      (reset),
    .vsync_in   (vsync_in),
    .frame_edge (w_frame_edge)
  );

  // Snoop stores into the X table; writes are held off while in reset
  always_ff @(posedge clock) begin
    if (reset && wren && w_x_in) begin
      r_x_mem[w_x_idx] <= wdata[COORD_W-1:0];
    end
  end

  // Snoop stores into the Y table; writes are held off while in reset
  always_ff @(posedge clock) begin
    if (reset && wren && w_y_in) begin
      r_y_mem[w_y_idx] <= wdata[COORD_W-1:0];
    end
  end

`ifdef DOT_READBACK_FRAME_COUNT_EN
  logic [DOT_COUNT_W-1:0] r_frame_count;

  // Free-running frame counter, wraps at 16 bits
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_frame_count <= '0;
    end else if (w_frame_edge) begin
      r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign w_frame_count = r_frame_count;
`else
  assign w_frame_count = '0;
`endif

  // Status reflects state before this edge; a status load sees the pre-clear value
  assign w_status_word = dot_status_word(r_frame_pending, r_overrun, w_frame_count);

  // Pending/overrun flags: a frame edge wins over read-to-clear on the same cycle,
  // and overrun only sets when a previous frame was still unacknowledged
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_frame_pending <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      if (w_frame_edge) begin
        r_frame_pending <= 1'b1;
      end else if (w_status_rd) begin
        r_frame_pending <= 1'b0;
      end

      if (w_frame_edge && r_frame_pending) begin
        r_overrun <= 1'b1;
      end else if (w_status_rd) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Registered load return: one-cycle latency, zero and no hit for misses
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rdata <= '0;
      r_hit   <= 1'b0;
    end else begin
      case (w_rd_sel)
        RD_X: begin
          r_rdata <= {{(32-COORD_W){1'b0}}, r_x_mem[w_x_idx]};
          r_hit   <= 1'b1;
        end
        RD_Y: begin
          r_rdata <= {{(32-COORD_W){1'b0}}, r_y_mem[w_y_idx]};
          r_hit   <= 1'b1;
        end
        RD_STATUS: begin
          r_rdata <= w_status_word;
          r_hit   <= 1'b1;
        end
        default: begin
          r_rdata <= '0;
          r_hit   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign hit   = r_hit;

endmodule
